// File: rtl/seq_detector_param.sv
// Parametrised serial bit-sequence detector with runtime-loaded pattern/length,
// overlap mode and saturating match counter. Optional idle-gap flush: SEQ_DET_TIMEOUT_EN.
module seq_detector_param #(
    parameter int PAT_W       = 8,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_enable,
    input  logic                       i_bit_valid,
    input  logic                       i_bit_seq,
    input  logic                       i_cfg_load,
    input  logic [PAT_W-1:0]           i_pattern,
    input  logic [$clog2(PAT_W+1)-1:0] i_pat_len,
    input  logic                       i_overlap,
    input  logic                       i_cnt_clear,
    output logic                       o_seq_detected,
    output logic [CNT_W-1:0]           o_match_count,
    output logic                       o_count_sat,
    output logic                       o_timeout
);

    localparam int LW = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HUNT = 2'd2
    } state_t;

    // TIMEOUT_CYC below 2 is not a legal configuration; this block marks that case.
    if (TIMEOUT_CYC < 2) begin : g_timeout_range_bad
    end

    // Lengths outside 2..PAT_W fall back to the full pattern width.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
        if ((len < LW'(2)) || (len > LW'(PAT_W))) begin
            return LW'(PAT_W);
        end else begin
            return len;
        end
    endfunction

    function automatic logic [PAT_W-1:0] len_mask(input logic [LW-1:0] len);
        logic [PAT_W-1:0] m;
        m = '0;
        for (int i = 0; i < PAT_W; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

    state_t            state_q, state_d;
    logic [PAT_W-1:0]  hist_q,  hist_d;
    logic [LW-1:0]     fill_q,  fill_d;
    logic [PAT_W-1:0]  pat_q,   pat_d;
    logic [LW-1:0]     len_q,   len_d;
    logic              ovl_q,   ovl_d;
    logic              det_q,   det_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              sat_q,   sat_d;

    logic [PAT_W-1:0]  hist_sh_s;
    logic [LW-1:0]     fill_inc_s;
    logic              hit_s;

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYC + 1);
    logic [GW-1:0]     gap_q, gap_d;
    logic [GW-1:0]     gap_inc_s;
    logic              to_q,  to_d;
`endif

    // Candidate history/fill for an accepted bit and the resulting match decision.
    always_comb begin
        hist_sh_s  = {hist_q[PAT_W-2:0], i_bit_seq};
        if (fill_q >= len_q) begin
            fill_inc_s = len_q;
        end else begin
            fill_inc_s = fill_q + LW'(1);
        end
        hit_s = (fill_inc_s == len_q) &&
                (((hist_sh_s ^ pat_q) & len_mask(len_q)) == '0);
    end

    // Next-state logic: configuration load, enable, accepted bits and gaps.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        det_d   = 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
        gap_d     = gap_q;
        gap_inc_s = gap_q + GW'(1);
        to_d      = 1'b0;
`endif
        if (i_cfg_load) begin
            pat_d   = i_pattern;
            len_d   = clamp_len(i_pat_len);
            ovl_d   = i_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = i_enable ? ST_FILL : ST_IDLE;
`ifdef SEQ_DET_TIMEOUT_EN
            gap_d   = '0;
`endif
        end else if (!i_enable) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_IDLE;
`ifdef SEQ_DET_TIMEOUT_EN
            gap_d   = '0;
`endif
        end else if (i_bit_valid) begin
            hist_d = hist_sh_s;
            fill_d = fill_inc_s;
            det_d  = hit_s;
`ifdef SEQ_DET_TIMEOUT_EN
            gap_d  = '0;
`endif
            if (hit_s && !ovl_q) begin
                // Non-overlapping: the next match must be built from fresh bits.
                hist_d  = '0;
                fill_d  = '0;
                state_d = ST_FILL;
            end else if (fill_inc_s == len_q) begin
                state_d = ST_HUNT;
            end else begin
                state_d = ST_FILL;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FILL;
`ifdef SEQ_DET_TIMEOUT_EN
                    gap_d   = '0;
`endif
                end
                ST_FILL, ST_HUNT: begin
                    state_d = state_q;
`ifdef SEQ_DET_TIMEOUT_EN
                    if (gap_inc_s == GW'(TIMEOUT_CYC)) begin
                        hist_d  = '0;
                        fill_d  = '0;
                        state_d = ST_FILL;
                        gap_d   = '0;
                        to_d    = 1'b1;
                    end else begin
                        gap_d   = gap_inc_s;
                    end
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            endcase
        end
    end

    // Saturating match counter; clear overrides a coincident increment.
    always_comb begin
        cnt_d = cnt_q;
        if (i_cnt_clear) begin
            cnt_d = '0;
        end else if (det_d && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        sat_d = &cnt_d;
    end

    // State, history, configuration and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= LW'(PAT_W);
            ovl_q   <= 1'b0;
            det_q   <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            det_q   <= det_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

`ifdef SEQ_DET_TIMEOUT_EN
    // Idle-gap counter and timeout pulse register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gap_q <= '0;
            to_q  <= 1'b0;
        end else begin
            gap_q <= gap_d;
            to_q  <= to_d;
        end
    end

    assign o_timeout = to_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_seq_detected = det_q;
    assign o_match_count  = cnt_q;
    assign o_count_sat    = sat_q;

endmodule
